// File: rtl/display_sete_leitor.sv
// display_sete_leitor: readback receiver for the multiplexed seven-segment display bus.
// It samples the active-low segment lines and the one-hot digit select. A pattern is
// accepted only after it has been seen unchanged for STABLE_CYCLES consecutive samples.
// Each accepted pattern is decoded back to BCD for the digit that was selected.
//
// Ports:
//   clock      - system clock; all logic is on the rising edge
//   reset      - asynchronous active-low reset
//   seg_in     - segment lines, active-low, bit 6 = a ... bit 0 = g
//   dig_sel    - one-hot, active-high digit select
//   digitos    - decoded BCD; digit k occupies [4k+3:4k] (4'hF = blank or never written)
//   validos    - per digit: the last accepted pattern was a digit 0-9
//   erro       - per digit: the last accepted pattern was illegal
//   atualizado - one-cycle pulse on every acceptance
//   indice     - index of the digit accepted with the current pulse; holds afterwards
module display_sete_leitor #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic [6:0]                                            seg_in,
  input  logic [NUM_DIGITS-1:0]                                 dig_sel,
  output logic [4*NUM_DIGITS-1:0]                               digitos,
  output logic [NUM_DIGITS-1:0]                                 validos,
  output logic [NUM_DIGITS-1:0]                                 erro,
  output logic                                                  atualizado,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] indice
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCount = 2'd1;
  localparam logic [1:0] StHeld  = 2'd2;

  localparam logic [1:0] KindDigit   = 2'd0;
  localparam logic [1:0] KindBlank   = 2'd1;
  localparam logic [1:0] KindIllegal = 2'd2;

  // Input register (_q) and the sample before it (_p), used for change detection.
  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] sel_q, sel_p;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_q <= 7'h7f;
      seg_p <= 7'h7f;
      sel_q <= '0;
      sel_p <= '0;
    end else begin
      seg_q <= seg_in;
      sel_q <= dig_sel;
      seg_p <= seg_q;
      sel_p <= sel_q;
    end
  end

  logic          sel_onehot;
  logic          changed;
  logic [IW-1:0] sel_idx;

  assign sel_onehot = $onehot(sel_q);
  // A select change and a segment change on the same edge count as a single change.
  assign changed    = (sel_q != sel_p) || (seg_q != seg_p);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (sel_q[i]) sel_idx = IW'(i);
    end
  end

  // Segment pattern (abcdefg, active-low) back to BCD.
  logic [1:0] dec_kind;
  logic [3:0] dec_val;

  always_comb begin
    dec_kind = KindDigit;
    dec_val  = 4'h0;
    case (seg_q)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      7'b1111111: begin
        dec_kind = KindBlank;
        dec_val  = 4'hf;
      end
      default:    dec_kind = KindIllegal;
    endcase
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StCount, StHeld: begin
        if (changed) begin
          if (sel_onehot) begin
            state_d = StCount;
            cnt_d   = CW'(1);
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else if (state_q == StCount) begin
          // Accept on the same edge the count reaches STABLE_CYCLES.
          if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            accept  = 1'b1;
            state_d = StHeld;
            cnt_d   = CW'(STABLE_CYCLES);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // Held and unchanged: counter stays saturated, nothing re-accepted.
      end
      default: begin
        if (sel_onehot) begin
          state_d = StCount;
          cnt_d   = CW'(1);
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digitos    <= '1;
      validos    <= '0;
      erro       <= '0;
      atualizado <= 1'b0;
      indice     <= '0;
    end else begin
      atualizado <= accept;
      if (accept) begin
        indice <= sel_idx;
        case (dec_kind)
          KindDigit, KindBlank: begin
            digitos[4*int'(sel_idx) +: 4] <= dec_val;
            validos[sel_idx]              <= (dec_kind == KindDigit);
            erro[sel_idx]                 <= 1'b0;
          end
          default: begin
            // Illegal pattern keeps the last good BCD value.
            validos[sel_idx] <= 1'b0;
            erro[sel_idx]    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
